quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Quadrature (A/B) decoder that turns raw phase inputs into single-cycle step pulses plus a direction level.
- Drives the enable/up command interface of the synchronous up/down counter. It is the producer end of that interface; the counter is the consumer.
- Synchronises asynchronous phase pins, filters glitches, decodes Gray-code transitions and flags illegal jumps.

Parameters:
- FILT_CYCLES, 4, consecutive sampling edges a new A/B value must hold before it is accepted; legal range 1..15.
- CNT_W, 4, position counter width; used only when QUAD_POS_COUNT_EN is defined.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- quad_a  input  1  phase A, asynchronous to clk.
- quad_b  input  1  phase B, asynchronous to clk.
- enable  input  1  1 = step/err generation active.
- err_clr  input  1  synchronous clear of err.
- step  output  1  one-cycle pulse per accepted legal transition.
- up  output  1  direction of the last legal transition (1 = forward).
- err  output  1  sticky illegal-transition flag.
- ab_state  output  2  filtered {A,B} state.

Behaviour:
- Reset (async assert, sync-deassert use by the environment):
  - step=0, up=1, err=0, ab_state=2'b00.
  - Synchroniser flops and filter counter = 0.
- Synchroniser: two flops per phase. sync2 is the second stage.
- Filter:
  - ab_state adopts value V only after sync2 has shown V on FILT_CYCLES consecutive edges, with V != ab_state.
  - Any change of sync2 before then restarts qualification.
  - A pulse shorter than FILT_CYCLES cycles (after sync) is never accepted.
- Latency: first clk edge sampling the new pin value = E0. ab_state updates at edge E0+1+FILT_CYCLES. step is high during the cycle after edge E0+2+FILT_CYCLES. Default: 7 edges.
- Decode (registered, one cycle after ab_state change). Forward order is 00->01->11->10->00.
  - Forward neighbour: step=1, up=1.
  - Reverse neighbour: step=1, up=0.
  - Both bits changed (00<->11, 01<->10): step=0, up unchanged, err=1.
- Only one ab_state change can occur per cycle, so step never asserts on consecutive cycles more often than the filter allows.
- up holds its value between steps.
- enable=0:
  - Synchroniser, filter and ab_state keep tracking.
  - step forced 0; err not set; up unchanged.
  - Re-enabling produces no step for transitions that already happened.
- err: sticky.
  - err_clr=1 clears it on the next edge.
  - If an illegal transition and err_clr occur in the same cycle, err=1 (set wins).
- Reset mid-operation: all state returns to reset values immediately. Pins are requalified from ab_state=00.
  - If the pins sit at 11 at release, the first accepted change is 00->11 and sets err (enable=1). This is intended.

Optional Feature:
- Macro: QUAD_POS_COUNT_EN.
- Defined:
  - Adds ports load (input, 1), load_val (input, CNT_W) and pos (output, CNT_W).
  - pos resets to 0 and increments or decrements in the same cycle step is asserted; the pos update is visible one edge after step.
  - Wraps modulo 2^CNT_W: 15+1 -> 0, 0-1 -> 15 at CNT_W=4.
  - load=1 sets pos=load_val and overrides a coincident step.
  - load works regardless of enable.
- Undefined: those ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Forward sweep: reset, enable=1, apply AB 00->01->11->10->00, each held 10 cycles -> 4 step pulses, up=1, first pulse 7 edges after the first pin change, err=0.
- Reverse sweep: from 00 apply 10->11->01->00 -> 4 step pulses with up=0, ab_state ends 00.
- Glitch rejection (FILT_CYCLES=4): A high for 3 cycles then low -> no step, ab_state stays 00; A high for 4 cycles -> ab_state=01 and one step with up=1.
- Illegal jump:
  - 00->11 -> err=1, no step, up unchanged.
  - err_clr together with a second illegal jump -> err stays 1.
  - err_clr alone -> err=0 next edge.
- enable=0 during 2 forward transitions -> no step, ab_state=11. Re-enable and apply 11->10 -> exactly one step, up=1.
- QUAD_POS_COUNT_EN defined:
  - load_val=4'hF with load=1, then one forward step -> pos=0.
  - One reverse step -> pos=F.
  - Assert rst_n=0 mid-sequence -> pos=0, step=0, up=1 immediately.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder that produces a one-cycle step pulse, a direction level and a sticky illegal-jump flag.
// Optional position counter is enabled by defining QUAD_POS_COUNT_EN.
module quad_step_decoder #(
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             enable,
  input  logic             err_clr,
`ifdef QUAD_POS_COUNT_EN
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] pos,
`endif
  output logic             step,
  output logic             up,
  output logic             err,
  output logic [1:0]       ab_state
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES);

  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic [1:0] cand_reg;
  logic [3:0] filt_cnt_reg;
  logic [1:0] ab_reg;
  logic [1:0] ab_prev_reg;
  logic       step_reg;
  logic       up_reg;
  logic       err_reg;

  logic       fwd_move;
  logic       rev_move;
  logic       bad_move;
  logic [3:0] filt_cnt_inc;

  assign filt_cnt_inc = filt_cnt_reg + 4'd1;

  // Two-flop synchroniser per phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= {quad_a, quad_b};
      sync2_reg <= sync1_reg;
    end
  end

  // Filter: a candidate value must be seen on FILT_CYCLES consecutive edges; any change restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg     <= 2'b00;
      filt_cnt_reg <= 4'd0;
      ab_reg       <= 2'b00;
    end else if (sync2_reg == ab_reg) begin
      filt_cnt_reg <= 4'd0;
    end else if (filt_cnt_reg == 4'd0 || sync2_reg != cand_reg) begin
      cand_reg <= sync2_reg;
      if (FILT_CYCLES == 1) begin
        ab_reg       <= sync2_reg;
        filt_cnt_reg <= 4'd0;
      end else begin
        filt_cnt_reg <= 4'd1;
      end
    end else if (filt_cnt_inc == FILT_LAST) begin
      ab_reg       <= sync2_reg;
      filt_cnt_reg <= 4'd0;
    end else begin
      filt_cnt_reg <= filt_cnt_inc;
    end
  end

  // Classify the transition between last cycle's and this cycle's filtered state
  always_comb begin
    fwd_move = 1'b0;
    rev_move = 1'b0;
    bad_move = 1'b0;
    case ({ab_prev_reg, ab_reg})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd_move = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev_move = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad_move = 1'b1;
      default: ;
    endcase
  end

  // ab_prev tracks even while disabled so re-enabling never replays old transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_prev_reg <= 2'b00;
      step_reg    <= 1'b0;
      up_reg      <= 1'b1;
      err_reg     <= 1'b0;
    end else begin
      ab_prev_reg <= ab_reg;
      step_reg    <= enable & (fwd_move | rev_move);
      if (enable && (fwd_move || rev_move))
        up_reg <= fwd_move;
      if (enable && bad_move)
        err_reg <= 1'b1;
      else if (err_clr)
        err_reg <= 1'b0;
    end
  end

`ifdef QUAD_POS_COUNT_EN
  logic [CNT_W-1:0] pos_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pos_reg <= '0;
    else if (load)
      pos_reg <= load_val;
    else if (step_reg)
      pos_reg <= up_reg ? pos_reg + CNT_W'(1) : pos_reg - CNT_W'(1);
  end

  assign pos = pos_reg;
`endif

  assign step     = step_reg;
  assign up       = up_reg;
  assign err      = err_reg;
  assign ab_state = ab_reg;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: vector table plus a step scoreboard keyed on expected cycle.
// Covers the QUAD_POS_COUNT_EN counter when that macro is defined.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       enable = 1'b0;
  logic       err_clr = 1'b0;
  logic       step;
  logic       up;
  logic       err;
  logic [1:0] ab_state;
`ifdef QUAD_POS_COUNT_EN
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] pos;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  quad_step_decoder #(.FILT_CYCLES(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .enable   (enable),
    .err_clr  (err_clr),
`ifdef QUAD_POS_COUNT_EN
    .load     (load),
    .load_val (load_val),
    .pos      (pos),
`endif
    .step     (step),
    .up       (up),
    .err      (err),
    .ab_state (ab_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic up;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] ab;
    logic       en;
    int         hold;
    logic       exp_step;
    logic       exp_up;
    logic       exp_err;
    logic       chk;
  } vec_t;
  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Every step pulse must match the oldest pending expectation in cycle and direction
  always @(negedge clk) begin
    if (rst_n && step === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: got step=1 up=%0b expected no step (cycle %0d)", up, cyc);
      end else begin
        e = sb.pop_front();
        check("step_cycle", cyc, e.cyc);
        check("step_up", {31'd0, up}, {31'd0, e.up});
      end
    end
  end

  // Called just after a rising edge; returns just after the rising edge ending the hold.
  task automatic run_vec(input vec_t v, input int idx);
    int k;
    quad_a = v.ab[1];
    quad_b = v.ab[0];
    enable = v.en;
    k = cyc;
    if (v.exp_step) sb.push_back('{k + 7, v.exp_up});
    repeat (v.hold - 1) @(posedge clk);
    if (v.chk) begin
      @(negedge clk);
      check($sformatf("v%0d_ab_state", idx), {30'd0, ab_state}, {30'd0, v.ab});
      check($sformatf("v%0d_up", idx), {31'd0, up}, {31'd0, v.exp_up});
      check($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
      check($sformatf("v%0d_pending_steps", idx), sb.size(), 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ab, en, hold, exp_step, exp_up, exp_err, chk
    vecs[0]  = '{2'b01, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b1};  // forward sweep
    vecs[1]  = '{2'b11, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{2'b10, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{2'b10, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1};  // reverse sweep
    vecs[5]  = '{2'b11, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'b01, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b00, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b01, 1'b1, 3,  1'b0, 1'b0, 1'b0, 1'b0};  // 3-cycle glitch
    vecs[9]  = '{2'b00, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 1'b1, 4,  1'b1, 1'b1, 1'b0, 1'b0};  // 4-cycle pulse is accepted
    vecs[11] = '{2'b00, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{2'b11, 1'b1, 10, 1'b0, 1'b0, 1'b1, 1'b1};  // illegal 00->11
    vecs[13] = '{2'b01, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b1};  // disabled tracking
    vecs[14] = '{2'b11, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{2'b10, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b1};  // re-enabled: one step
    vecs[16] = '{2'b00, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{2'b10, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{2'b01, 1'b1, 10, 1'b0, 1'b0, 1'b1, 1'b1};  // illegal 10->01

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_step", {31'd0, step}, 32'd0);
    check("reset_up", {31'd0, up}, 32'd1);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_ab_state", {30'd0, ab_state}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b1;

    for (int i = 0; i <= 12; i++) run_vec(vecs[i], i);

    // Illegal 11->00 with err_clr held exactly across the edge that flags it
    begin
      quad_a = 1'b0;
      quad_b = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      @(negedge clk);
      check("errclr_with_illegal_err", {31'd0, err}, 32'd1);
      check("errclr_with_illegal_ab", {30'd0, ab_state}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      @(negedge clk);
      check("errclr_alone_err", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1;
    end

    for (int i = 13; i <= 18; i++) run_vec(vecs[i], i);

    // Asynchronous reset mid-operation, then release with pins at 11
    begin
      quad_a = 1'b1;
      quad_b = 1'b1;
      rst_n = 1'b0;
      #1;
      check("midrst_step", {31'd0, step}, 32'd0);
      check("midrst_up", {31'd0, up}, 32'd1);
      check("midrst_err", {31'd0, err}, 32'd0);
      check("midrst_ab_state", {30'd0, ab_state}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("release_at_11_err", {31'd0, err}, 32'd1);
      check("release_at_11_ab", {30'd0, ab_state}, 32'd3);
      check("release_at_11_up", {31'd0, up}, 32'd1);
      @(posedge clk);
      #1;
    end

`ifdef QUAD_POS_COUNT_EN
    begin
      vec_t v;
      load = 1'b1;
      load_val = 4'hF;
      @(posedge clk);
      #1;
      load = 1'b0;
      check("pos_load", {28'd0, pos}, 32'hF);
      v = '{2'b10, 1'b1, 10, 1'b1, 1'b1, 1'b1, 1'b1};
      run_vec(v, 100);
      check("pos_wrap_up", {28'd0, pos}, 32'h0);
      v = '{2'b11, 1'b1, 10, 1'b1, 1'b0, 1'b1, 1'b1};
      run_vec(v, 101);
      check("pos_wrap_down", {28'd0, pos}, 32'hF);
      rst_n = 1'b0;
      #1;
      check("pos_reset", {28'd0, pos}, 32'h0);
      check("pos_reset_step", {31'd0, step}, 32'd0);
      check("pos_reset_up", {31'd0, up}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL final_pending_steps: got %0d outstanding expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
